// File: rtl/score_glyph_writer_pkg.sv
// Shared display constants and the glyph writer state encoding.
package pong_gui_pkg;

   localparam int RGB_W       = 3;
   localparam int GLYPH_W     = 11;
   localparam int GLYPH_H     = 16;
   localparam int GLYPH_DEPTH = GLYPH_W * GLYPH_H;

   localparam logic [RGB_W-1:0] RGB_BLACK = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } glyph_state_e;

endpackage

// File: rtl/score_glyph_writer_if.sv
// Loader-side pixel stream plus renderer-side row/col -> rgb read port of the glyph writer.
interface score_glyph_writer_if
   import pong_gui_pkg::*;
;
   logic             start;
   logic             pix_valid;
   logic [RGB_W-1:0] pix_data;
   logic             pix_ready;
   logic             busy;
   logic             done;
   logic [9:0]       row;
   logic [9:0]       col;
   logic [RGB_W-1:0] rgb;

   modport master (
      output start, pix_valid, pix_data, row, col,
      input  pix_ready, busy, done, rgb
   );

   modport slave (
      input  start, pix_valid, pix_data, row, col,
      output pix_ready, busy, done, rgb
   );

endinterface

// File: rtl/score_glyph_writer_ram.sv
// Glyph pixel memory: one synchronous write port, one asynchronous read port, no reset.
module glyph_ram #(
   parameter int DEPTH  = 176,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/score_glyph_writer.sv
// Writable glyph store: raster-order pixel loader with a blanked, range-checked read port.
module score_glyph_writer
   import pong_gui_pkg::*;
#(
   parameter int WIDTH  = GLYPH_W,
   parameter int HEIGHT = GLYPH_H,
   parameter int DEPTH  = WIDTH * HEIGHT,
   parameter int ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   score_glyph_writer_if.slave  gw
);

   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
   localparam logic [9:0]        WIDTH_LIM  = 10'(WIDTH);
   localparam logic [9:0]        HEIGHT_LIM = 10'(HEIGHT);
   localparam logic [ADDR_W-1:0] ROW_PITCH  = ADDR_W'(WIDTH);

   glyph_state_e      state_q;
   glyph_state_e      state_d;
   logic [COL_W-1:0]  wcol_q;
   logic [ROW_W-1:0]  wrow_q;
   logic              loaded_q;

   logic              accept;
   logic              wr_en;
   logic              last_pix;
   logic              in_range;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [RGB_W-1:0]  rd_data;

   assign accept   = gw.pix_valid & gw.pix_ready;
   // start has priority: a beat accepted alongside start is dropped
   assign wr_en    = accept & ~gw.start;
   assign last_pix = (wcol_q == COL_LAST) && (wrow_q == ROW_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gw.start) state_d = LOAD;
         LOAD:    if (wr_en && last_pix) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are purely state-decoded, independent of pix_valid
   always_comb begin
      gw.pix_ready = 1'b0;
      gw.busy      = 1'b0;
      gw.done      = 1'b0;
      case (state_q)
         LOAD: begin
            gw.pix_ready = 1'b1;
            gw.busy      = 1'b1;
         end
         DONE:    gw.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcol_q <= '0;
         wrow_q <= '0;
      end else if (gw.start && (state_q != DONE)) begin
         wcol_q <= '0;
         wrow_q <= '0;
      end else if (wr_en) begin
         if (wcol_q == COL_LAST) begin
            wcol_q <= '0;
            wrow_q <= wrow_q + 1'b1;
         end else begin
            wcol_q <= wcol_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaded_q <= 1'b0;
      end else if (state_q == DONE) begin
         loaded_q <= 1'b1;
      end
   end

   assign wr_addr = ADDR_W'(wrow_q) * ROW_PITCH + ADDR_W'(wcol_q);

   // Truncated address math is safe only because in_range gates the result
   assign rd_addr  = ADDR_W'(gw.col) + ADDR_W'(gw.row) * ROW_PITCH;
   assign in_range = (gw.col < WIDTH_LIM) && (gw.row < HEIGHT_LIM) &&
                     loaded_q && (state_q != LOAD);

   assign gw.rgb = in_range ? rd_data : RGB_BLACK;

   glyph_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (RGB_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (gw.pix_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule
